// File: rtl/alu_pkg.sv
// Shared definitions for the sequential ALU: one-hot op positions and FSM states.
// Imported by the interface, the iterative core and the top.
package alu_pkg;

  localparam int SIG_COUNT = 13;

  localparam int OP_ADD  = 0;
  localparam int OP_SUB  = 1;
  localparam int OP_AND  = 2;
  localparam int OP_OR   = 3;
  localparam int OP_SHR  = 4;
  localparam int OP_SHL  = 5;
  localparam int OP_ROR  = 6;
  localparam int OP_ROL  = 7;
  localparam int OP_NEG  = 8;
  localparam int OP_NOT  = 9;
  localparam int OP_SHRA = 10;
  localparam int OP_MUL  = 11;
  localparam int OP_DIV  = 12;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_MUL,
    ST_DIV,
    ST_DONE
  } state_e;

endpackage

// File: rtl/seq_alu_if.sv
// Request/response bundle between the datapath controller and the ALU.
// The controller side is master; the ALU side is slave.
interface seq_alu_if #(
  parameter int BITS = 32
);
  import alu_pkg::*;

  logic                 start;
  logic [SIG_COUNT-1:0] ctrl_signal;
  logic [BITS-1:0]      X;
  logic [BITS-1:0]      Y;
  logic                 busy;
  logic                 done;
  logic [2*BITS-1:0]    result;
  logic                 div_zero;
  logic                 op_err;

  modport master (
    output start, ctrl_signal, X, Y,
    input  busy, done, result, div_zero, op_err
  );

  modport slave (
    input  start, ctrl_signal, X, Y,
    output busy, done, result, div_zero, op_err
  );

endinterface

// File: rtl/muldiv_core.sv
// Iterative radix-2 Booth multiplier and restoring divider sharing one accumulator.
// One bit per step; res presents the finished {HI,LO} combinationally during the last step.
module muldiv_core #(
  parameter int BITS = 32
) (
  input  logic              clk,
  input  logic              clr_n,
  input  logic              load,
  input  logic              step,
  input  logic              is_div,
  input  logic [BITS-1:0]   x,
  input  logic [BITS-1:0]   y,
  output logic              last,
  output logic [2*BITS-1:0] res
);

  localparam int CNT_W = $clog2(BITS);

  // hi is one bit wider so Booth partial sums with a -2^(BITS-1) multiplicand never overflow
  logic [BITS:0]      hi_q, hi_d, m_q, sum, shifted;
  logic [BITS-1:0]    lo_q, lo_d, x_abs, y_abs, quo, rem;
  logic               qm1_q, qm1_d, div_q, x_neg_q, q_neg_q;
  logic [CNT_W-1:0]   cnt_q;

  assign x_abs = x[BITS-1] ? -x : x;
  assign y_abs = y[BITS-1] ? -y : y;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      hi_q    <= '0;
      lo_q    <= '0;
      m_q     <= '0;
      qm1_q   <= 1'b0;
      div_q   <= 1'b0;
      x_neg_q <= 1'b0;
      q_neg_q <= 1'b0;
      cnt_q   <= '0;
    end else if (load) begin
      hi_q    <= '0;
      qm1_q   <= 1'b0;
      cnt_q   <= '0;
      div_q   <= is_div;
      x_neg_q <= x[BITS-1];
      q_neg_q <= x[BITS-1] ^ y[BITS-1];
      if (is_div) begin
        lo_q <= x_abs;
        m_q  <= {1'b0, y_abs};
      end else begin
        lo_q <= x;
        m_q  <= {y[BITS-1], y};
      end
    end else if (step) begin
      hi_q  <= hi_d;
      lo_q  <= lo_d;
      qm1_q <= qm1_d;
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  // NOTE: every variable gets a default at the top of always_comb so no path infers a latch.
  always_comb begin
    sum     = hi_q;
    shifted = {hi_q[BITS-1:0], lo_q[BITS-1]};
    hi_d    = hi_q;
    lo_d    = lo_q;
    qm1_d   = qm1_q;
    if (div_q) begin
      hi_d = shifted;
      lo_d = {lo_q[BITS-2:0], 1'b0};
      if (shifted >= m_q) begin
        hi_d    = shifted - m_q;
        lo_d[0] = 1'b1;
      end
    end else begin
      case ({lo_q[0], qm1_q})
        2'b01:   sum = hi_q + m_q;
        2'b10:   sum = hi_q - m_q;
        default: sum = hi_q;
      endcase
      hi_d  = {sum[BITS], sum[BITS:1]};
      lo_d  = {sum[0], lo_q[BITS-1:1]};
      qm1_d = lo_q[0];
    end
  end

  // Sign fix-up on the final step: quotient follows X^Y, remainder follows X
  assign quo  = q_neg_q ? -lo_d : lo_d;
  assign rem  = x_neg_q ? -hi_d[BITS-1:0] : hi_d[BITS-1:0];
  assign res  = div_q ? {rem, quo} : {hi_d[BITS-1:0], lo_d};
  assign last = (cnt_q == CNT_W'(BITS - 1));

endmodule

// File: rtl/seq_alu.sv
// Multi-cycle ALU: one-hot op select, single-cycle logic/arith/shift ops, iterative MUL/DIV.
// Holds the control FSM, operand decode, flag logic and the {HI,LO} result register.
module seq_alu
  import alu_pkg::*;
#(
  parameter int BITS = 32
) (
  input  logic        clk,
  input  logic        clr_n,
  seq_alu_if.slave    bus
);

  localparam int SH_W = $clog2(BITS);

  state_e            state_q, state_d;
  logic              accept, one_hot, is_mul, is_div, y_zero, iter_go, last;
  logic [SH_W-1:0]   sh;
  logic [BITS-1:0]   lo;
  logic [2*BITS-1:0] quick_res, core_res, result_q;
  logic              div_zero_q, op_err_q;

  assign accept  = (state_q == ST_IDLE) && bus.start;
  assign one_hot = $onehot(bus.ctrl_signal);
  assign is_mul  = one_hot && bus.ctrl_signal[OP_MUL];
  assign is_div  = one_hot && bus.ctrl_signal[OP_DIV];
  assign y_zero  = (bus.Y == '0);
  assign iter_go = accept && (is_mul || (is_div && !y_zero));
  assign sh      = bus.Y[SH_W-1:0];

  muldiv_core #(.BITS(BITS)) u_core (
    .clk    (clk),
    .clr_n  (clr_n),
    .load   (iter_go),
    .step   (bus.busy),
    .is_div (is_div),
    .x      (bus.X),
    .y      (bus.Y),
    .last   (last),
    .res    (core_res)
  );

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          if (is_mul)                 state_d = ST_MUL;
          else if (is_div && !y_zero) state_d = ST_DIV;
          else                        state_d = ST_DONE;
        end
      end
      ST_MUL, ST_DIV: if (last) state_d = ST_DONE;
      ST_DONE:        state_d = ST_IDLE;
      default:        state_d = ST_IDLE;
    endcase
  end

  assign bus.busy = (state_q == ST_MUL) || (state_q == ST_DIV);
  assign bus.done = (state_q == ST_DONE);

  // Single-cycle ops are evaluated straight from the inputs and registered at the accepting edge
  always_comb begin
    lo = '0;
    if      (bus.ctrl_signal[OP_ADD])  lo = bus.X + bus.Y;
    else if (bus.ctrl_signal[OP_SUB])  lo = bus.X - bus.Y;
    else if (bus.ctrl_signal[OP_AND])  lo = bus.X & bus.Y;
    else if (bus.ctrl_signal[OP_OR])   lo = bus.X | bus.Y;
    else if (bus.ctrl_signal[OP_SHR])  lo = bus.X >> sh;
    else if (bus.ctrl_signal[OP_SHL])  lo = bus.X << sh;
    else if (bus.ctrl_signal[OP_ROR])  lo = BITS'({bus.X, bus.X} >> sh);
    else if (bus.ctrl_signal[OP_ROL])  lo = BITS'(({bus.X, bus.X} << sh) >> BITS);
    else if (bus.ctrl_signal[OP_NEG])  lo = -bus.X;
    else if (bus.ctrl_signal[OP_NOT])  lo = ~bus.X;
    else if (bus.ctrl_signal[OP_SHRA]) lo = BITS'($signed(bus.X) >>> sh);
  end

  always_comb begin
    quick_res = '0;
    if (!one_hot)    quick_res = '0;
    else if (is_div) quick_res = {bus.X, {BITS{1'b1}}};
    else             quick_res = {{BITS{1'b0}}, lo};
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      result_q   <= '0;
      div_zero_q <= 1'b0;
      op_err_q   <= 1'b0;
    end else if (accept) begin
      div_zero_q <= is_div && y_zero;
      op_err_q   <= !one_hot;
      if (!iter_go) result_q <= quick_res;
    end else if (bus.busy && last) begin
      result_q <= core_res;
    end
  end

  assign bus.result   = result_q;
  assign bus.div_zero = div_zero_q;
  assign bus.op_err   = op_err_q;

endmodule
